// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared configuration, state encoding and helpers for the zeroheti core
package zeroheti_pkg;
    typedef struct packed {
        int unsigned num_irqs;
        int unsigned num_prio;
    } core_cfg_t;

    localparam core_cfg_t DefaultCfg = '{num_irqs: 64, num_prio: 16};
    localparam int unsigned VecEntryBytes = 4;

    typedef enum logic [1:0] {IDLE, FETCH_REQ, FETCH_RSP, REDIRECT} irq_taker_state_e;

    function automatic logic [31:0] mk_irq_cause(input logic [30:0] id);
        return {1'b1, id};
    endfunction
endpackage

// File: rtl/obi_bus.sv
// OBI_BUS: OBI request/response bundle with manager and subordinate views
interface OBI_BUS;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport Manager (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport Subordinate (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/zeroheti_vec_fetch.sv
// zeroheti_vec_fetch: single-outstanding OBI word read used to fetch vector table entries
module zeroheti_vec_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    output logic        granted_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        err_o,
    OBI_BUS.Manager     obi_mgr
);
    logic        req_q, pend_q;
    logic [31:0] addr_q;

    assign obi_mgr.req   = req_q;
    assign obi_mgr.addr  = addr_q;
    assign obi_mgr.we    = 1'b0;
    assign obi_mgr.be    = 4'hF;
    assign obi_mgr.wdata = '0;
    assign granted_o     = req_q & obi_mgr.gnt;
    // Responses only count while a granted read is pending; strays are dropped.
    assign done_o        = pend_q & obi_mgr.rvalid;
    assign data_o        = obi_mgr.rdata;
    assign err_o         = obi_mgr.err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
            addr_q <= '0;
        end else if (start_i) begin
            req_q  <= 1'b1;
            addr_q <= addr_i;
        end else if (granted_o) begin
            req_q  <= 1'b0;
            pend_q <= 1'b1;
        end else if (done_o) begin
            pend_q <= 1'b0;
        end
    end
endmodule

// File: rtl/zeroheti_irq_taker.sv
// zeroheti_irq_taker: core-side interrupt take, level tracking and shv handler redirect
module zeroheti_irq_taker
    import zeroheti_pkg::*;
#(
    parameter core_cfg_t CoreCfg   = DefaultCfg,
    localparam int       IrqWidth  = $clog2(CoreCfg.num_irqs),
    localparam int       PrioWidth = $clog2(CoreCfg.num_prio)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 irq_valid_i,
    input  logic [IrqWidth-1:0]  irq_id_i,
    input  logic [PrioWidth-1:0] irq_level_i,
    input  logic                 irq_shv_i,
    output logic                 irq_ack_o,
    output logic [IrqWidth-1:0]  irq_id_o,
    input  logic                 mie_i,
    input  logic [PrioWidth-1:0] mintthresh_i,
    input  logic [31:0]          mtvec_i,
    input  logic [31:0]          mtvt_i,
    input  logic                 boundary_i,
    input  logic                 mret_i,
    output logic                 take_o,
    output logic [31:0]          cause_o,
    output logic [PrioWidth-1:0] cur_level_o,
    output logic [PrioWidth-1:0] prev_level_o,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o,
    input  logic                 redirect_ready_i,
    output logic                 fault_o,
    OBI_BUS.Manager              obi_mgr
);
    irq_taker_state_e     state_q;
    logic [PrioWidth-1:0] cur_q, prev_q, thr_max;
    logic [31:0]          pc_q, trap_base, fetch_data;
    logic                 fault_q, eligible, take, fetch_granted, fetch_done, fetch_err;

    assign thr_max   = (cur_q > mintthresh_i) ? cur_q : mintthresh_i;
    assign eligible  = irq_valid_i & mie_i & (irq_level_i > thr_max);
    // rst_i is folded in so the same-cycle take outputs stay quiet while reset is held.
    assign take      = (state_q == IDLE) & ~rst_i & ~mret_i & eligible & boundary_i;
    assign trap_base = mtvec_i & 32'hFFFF_FFFC;

    assign take_o           = take;
    assign irq_ack_o        = take;
    assign irq_id_o         = take ? irq_id_i : '0;
    assign cause_o          = take ? mk_irq_cause(31'(irq_id_i)) : '0;
    assign cur_level_o      = cur_q;
    assign prev_level_o     = prev_q;
    assign redirect_valid_o = (state_q == REDIRECT);
    assign redirect_pc_o    = pc_q;
    assign fault_o          = fault_q;

    zeroheti_vec_fetch u_vec_fetch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (take & irq_shv_i),
        .addr_i    (mtvt_i + 32'(irq_id_i) * VecEntryBytes),
        .granted_o (fetch_granted),
        .done_o    (fetch_done),
        .data_o    (fetch_data),
        .err_o     (fetch_err),
        .obi_mgr   (obi_mgr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= '0;
            prev_q  <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mret_i) begin
                        cur_q  <= prev_q;
                        prev_q <= '0;
                    end else if (take) begin
                        prev_q  <= cur_q;
                        cur_q   <= irq_level_i;
                        pc_q    <= trap_base;
                        state_q <= irq_shv_i ? FETCH_REQ : REDIRECT;
                    end
                end
                FETCH_REQ: if (fetch_granted) state_q <= FETCH_RSP;
                FETCH_RSP: begin
                    if (fetch_done) begin
                        fault_q <= fetch_err;
                        pc_q    <= fetch_err ? trap_base : (fetch_data & 32'hFFFF_FFFE);
                        state_q <= REDIRECT;
                    end
                end
                REDIRECT: if (redirect_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zeroheti_irq_taker.sv
// tb_zeroheti_irq_taker: scoreboard bench; a transaction model predicts takes, levels, bus reads and redirects
module tb_zeroheti_irq_taker;
    import zeroheti_pkg::*;

    typedef struct {int c; logic [5:0] id; logic [31:0] cause;} take_t;
    typedef struct {int c; logic [3:0] cur; logic [3:0] prev;} lvl_t;
    typedef struct {int rs; int h; logic [31:0] pc; bit f;} redir_t;
    typedef struct {int c0; int c1; logic [31:0] addr;} obi_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        irq_valid, irq_shv, irq_ack, take, mie, boundary, mret;
    logic        redirect_valid, redirect_ready, fault;
    logic [5:0]  irq_id_in, irq_id_out;
    logic [3:0]  irq_level, thresh, cur_level, prev_level;
    logic [31:0] mtvec, mtvt, cause, redirect_pc;

    OBI_BUS obi();

    always #5 clk = ~clk;

    zeroheti_irq_taker dut (
        .clk_i(clk), .rst_i(rst),
        .irq_valid_i(irq_valid), .irq_id_i(irq_id_in), .irq_level_i(irq_level), .irq_shv_i(irq_shv),
        .irq_ack_o(irq_ack), .irq_id_o(irq_id_out),
        .mie_i(mie), .mintthresh_i(thresh), .mtvec_i(mtvec), .mtvt_i(mtvt),
        .boundary_i(boundary), .mret_i(mret),
        .take_o(take), .cause_o(cause), .cur_level_o(cur_level), .prev_level_o(prev_level),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .redirect_ready_i(redirect_ready),
        .fault_o(fault), .obi_mgr(obi)
    );

    int errors = 0, checks = 0;
    int cyc = 0, m_idle_at = 0, gnt_at = -1, rv_at = -1, ready_at = -1;
    logic [3:0]  m_cur = '0, m_prev = '0;
    logic [31:0] b_rdata = '0;
    bit          b_err = 1'b0;

    bit          s_rst = 1'b1, s_valid = 1'b0, s_shv = 1'b0, s_bnd = 1'b0, s_mret = 1'b0, s_mie = 1'b0;
    logic [5:0]  s_id = '0;
    logic [3:0]  s_level = '0, s_thresh = '0;
    logic [31:0] s_mtvec = '0, s_mtvt = '0;
    int          p_gw = 0, p_rw = 0, p_rdy = 0;
    bit          p_err = 1'b0;
    logic [31:0] p_rdata = '0;

    take_t  tq[$];
    lvl_t   lq[$];
    redir_t rq[$];
    obi_t   oq[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
        end
    endtask

    // Reference model: decides per cycle, from the architectural rules, what the taker must do.
    task automatic model();
        logic [3:0]  mx;
        logic [31:0] base, pc;
        int          rs;
        bit          f;
        if (s_rst) begin
            m_cur = '0; m_prev = '0; m_idle_at = cyc;
            tq.delete(); rq.delete(); oq.delete(); lq.delete();
            lq.push_back('{cyc, 4'd0, 4'd0});
            gnt_at = -1; ready_at = -1;
            return;
        end
        if (cyc < m_idle_at) return;
        mx = (m_cur > s_thresh) ? m_cur : s_thresh;
        if (s_mret) begin
            lq.push_back('{cyc + 1, m_prev, 4'd0});
            m_cur = m_prev; m_prev = '0;
        end else if (s_valid && s_mie && s_bnd && s_level > mx) begin
            tq.push_back('{cyc, s_id, 32'h8000_0000 + 32'(s_id)});
            lq.push_back('{cyc + 1, s_level, m_cur});
            m_prev = m_cur; m_cur = s_level;
            base = {s_mtvec[31:2], 2'b00};
            if (!s_shv) begin
                rs = cyc + 1; pc = base; f = 1'b0;
            end else begin
                gnt_at = cyc + 1 + p_gw;
                rv_at = gnt_at + 1 + p_rw;
                b_rdata = p_rdata; b_err = p_err;
                oq.push_back('{cyc + 1, gnt_at, s_mtvt + 32'(s_id) * 4});
                rs = rv_at + 1; f = p_err;
                pc = p_err ? base : {p_rdata[31:1], 1'b0};
            end
            ready_at = rs + p_rdy;
            rq.push_back('{rs, ready_at, pc, f});
            m_idle_at = ready_at + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rst = s_rst; irq_valid = s_valid; irq_id_in = s_id; irq_level = s_level; irq_shv = s_shv;
        boundary = s_bnd; mret = s_mret; mie = s_mie; thresh = s_thresh; mtvec = s_mtvec; mtvt = s_mtvt;
        obi.gnt = (cyc == gnt_at);
        if (cyc == rv_at) begin
            obi.rvalid = 1'b1; obi.rdata = b_rdata; obi.err = b_err;
        end else begin
            obi.rvalid = (cyc >= m_idle_at) && ($urandom_range(0, 7) == 0);
            obi.rdata = $urandom;
            obi.err = 1'($urandom_range(0, 1));
        end
        model();
        redirect_ready = (cyc == ready_at);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < m_idle_at) tick();
        tick();
    endtask

    task automatic fire(input logic [5:0] id, input logic [3:0] lvl, input bit shv);
        s_valid = 1'b1; s_id = id; s_level = lvl; s_shv = shv; s_bnd = 1'b1;
        tick();
        s_valid = 1'b0; s_bnd = 1'b0;
        wait_idle();
    endtask

    task automatic do_mret();
        s_mret = 1'b1; tick(); s_mret = 1'b0; tick();
    endtask

    // Monitor: compares every DUT output each cycle against the scoreboard heads.
    logic [3:0] ec = '0, ep = '0;
    always @(negedge clk) begin : monitor
        logic et, er, ef, eo;
        if (cyc > 0) begin
            if (rst) begin
                chk("reset_outputs", {31'd0, |{take, irq_ack, irq_id_out, cause, redirect_valid, redirect_pc,
                                               fault, obi.req, obi.addr}}, 32'd0);
                chk("reset_levels", {24'd0, cur_level, prev_level}, 32'd0);
            end else begin
                et = tq.size() > 0 && tq[0].c == cyc;
                chk("take", take, et);
                chk("ack", irq_ack, et);
                if (et) begin
                    chk("irq_id", irq_id_out, tq[0].id);
                    chk("cause", cause, tq[0].cause);
                    void'(tq.pop_front());
                end
                while (lq.size() > 0 && lq[0].c <= cyc) begin
                    ec = lq[0].cur; ep = lq[0].prev;
                    void'(lq.pop_front());
                end
                chk("cur_level", cur_level, ec);
                chk("prev_level", prev_level, ep);
                er = rq.size() > 0 && cyc >= rq[0].rs && cyc <= rq[0].h;
                ef = rq.size() > 0 && cyc == rq[0].rs && rq[0].f;
                chk("redirect_valid", redirect_valid, er);
                chk("fault", fault, ef);
                if (er) chk("redirect_pc", redirect_pc, rq[0].pc);
                if (rq.size() > 0 && cyc >= rq[0].h) void'(rq.pop_front());
                eo = oq.size() > 0 && cyc >= oq[0].c0 && cyc <= oq[0].c1;
                chk("obi_req", obi.req, eo);
                if (eo) begin
                    chk("obi_addr", obi.addr, oq[0].addr);
                    chk("obi_we_be", {27'd0, obi.we, obi.be}, 32'h0F);
                end
                if (oq.size() > 0 && cyc >= oq[0].c1) void'(oq.pop_front());
            end
        end
    end

    initial begin
        irq_valid = 0; irq_id_in = '0; irq_level = '0; irq_shv = 0; boundary = 0; mret = 0; mie = 0;
        thresh = '0; mtvec = '0; mtvt = '0; redirect_ready = 0;
        obi.gnt = 0; obi.rvalid = 0; obi.rdata = '0; obi.err = 0;
        s_rst = 1'b1; tick(); tick();
        s_rst = 1'b0; s_mie = 1'b1; s_thresh = 4'd0; s_mtvec = 32'h100; s_mtvt = 32'h2000;
        tick();
        fire(6'd5, 4'd3, 1'b0);
        do_mret();
        p_rdata = 32'h0000_4001;
        fire(6'd10, 4'd4, 1'b1);
        do_mret();
        s_thresh = 4'd2; fire(6'd7, 4'd2, 1'b0); s_thresh = 4'd0;
        s_mie = 1'b0; fire(6'd7, 4'd4, 1'b0); s_mie = 1'b1;
        s_valid = 1'b1; s_id = 6'd8; s_level = 4'd4; s_shv = 1'b0; s_bnd = 1'b0;
        repeat (3) tick();
        s_bnd = 1'b1; tick();
        s_valid = 1'b0; s_bnd = 1'b0; wait_idle();
        do_mret();
        fire(6'd1, 4'd3, 1'b0);
        fire(6'd2, 4'd5, 1'b0);
        do_mret();
        s_mret = 1'b1; s_valid = 1'b1; s_id = 6'd9; s_level = 4'd4; s_bnd = 1'b1; tick();
        s_mret = 1'b0; tick();
        s_valid = 1'b0; s_bnd = 1'b0; wait_idle();
        do_mret();
        s_mtvec = 32'h103; p_gw = 4; p_err = 1'b1;
        fire(6'd12, 4'd6, 1'b1);
        s_mtvec = 32'h100; p_gw = 0; p_err = 1'b0;
        do_mret();
        p_rw = 3;
        s_valid = 1'b1; s_id = 6'd20; s_level = 4'd2; s_shv = 1'b1; s_bnd = 1'b1; tick();
        s_valid = 1'b0; s_bnd = 1'b0; tick(); tick();
        s_rst = 1'b1; tick();
        s_rst = 1'b0; repeat (5) tick();
        p_rw = 0;
        s_mtvec = $urandom; s_mtvt = $urandom & 32'hFFFF_FFC0;
        repeat (3000) begin
            s_valid = 1'($urandom_range(0, 1)); s_id = 6'($urandom); s_level = 4'($urandom);
            s_shv = 1'($urandom_range(0, 1)); s_bnd = $urandom_range(0, 9) < 7;
            s_mret = $urandom_range(0, 19) == 0; s_mie = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 31) == 0) s_thresh = 4'($urandom_range(0, 4));
            p_gw = $urandom_range(0, 3); p_rw = $urandom_range(0, 2); p_rdy = $urandom_range(0, 2);
            p_err = $urandom_range(0, 9) == 0; p_rdata = $urandom;
            tick();
        end
        s_valid = 1'b0; s_mret = 1'b0; s_bnd = 1'b0;
        wait_idle();
        repeat (4) tick();
        chk("scoreboard_drained", tq.size() + rq.size() + oq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zeroheti_irq_taker.md
Name: zeroheti_irq_taker

Overview:
- Core-side end of the interrupt-controller handshake.
- Consumes the controller's valid/id/level/shv request and decides eligibility against MIE, the current level and the threshold.
- At an instruction boundary it takes the interrupt, returns ack+id, and tracks the current/previous interrupt level.
- For selective-hardware-vectored (shv) interrupts it fetches the handler address from the vector table over an OBI manager port, then redirects the fetch stage.

Parameters:
CoreCfg, zeroheti_pkg::DefaultCfg, core configuration (num_irqs, num_prio)
IrqWidth (localparam), $clog2(CoreCfg.num_irqs), interrupt id width
PrioWidth (localparam), $clog2(CoreCfg.num_prio), level width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
irq_valid_i  in  1  controller request valid
irq_id_i  in  IrqWidth  requested interrupt id
irq_level_i  in  PrioWidth  requested level
irq_shv_i  in  1  request is hardware-vectored
irq_ack_o  out  1  one-cycle acknowledge to controller
irq_id_o  out  IrqWidth  id being acknowledged
mie_i  in  1  mstatus.MIE
mintthresh_i  in  PrioWidth  level threshold
mtvec_i  in  32  trap base, direct mode
mtvt_i  in  32  vector table base, 64-byte aligned
boundary_i  in  1  pipeline at a killable instruction boundary
mret_i  in  1  mret retiring
take_o  out  1  pulse: flush pipeline, save mepc
cause_o  out  32  mcause value, valid with take_o
cur_level_o  out  PrioWidth  mintstatus.mil
prev_level_o  out  PrioWidth  mcause.mpil
redirect_valid_o  out  1  handler PC valid
redirect_pc_o  out  32  handler PC
redirect_ready_i  in  1  fetch accepts redirect
fault_o  out  1  pulse: vector fetch bus error
obi_mgr  interface  OBI_BUS.Manager  read-only vector fetch: we=0, be=4'hF

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE; cur_level and prev_level cleared to 0; every output 0, including obi req/addr.
- Eligibility is combinational: eligible = irq_valid_i & mie_i & (irq_level_i > max(cur_level, mintthresh_i)), unsigned compare.
- FSM states: IDLE, FETCH_REQ, FETCH_RSP, REDIRECT.
- IDLE:
  - If mret_i: cur_level <= prev_level, prev_level <= 0, no take that cycle. mret has priority over take.
  - Else if eligible & boundary_i, in the same cycle: take_o=1, irq_ack_o=1, irq_id_o=irq_id_i, cause_o = {1'b1, 31-bit zero-extended id}.
  - Registered on that take: id and shv latched; prev_level <= cur_level; cur_level <= irq_level_i.
  - Next state: FETCH_REQ if shv, else REDIRECT with pc = {mtvec_i[31:2],2'b00}.
- FETCH_REQ:
  - req=1, addr = mtvt_i + (id<<2), modulo 2^32.
  - Address and request are held stable until gnt; on gnt go to FETCH_RSP (earliest is the next cycle, no combinational req from state entry).
- FETCH_RSP:
  - Wait for rvalid.
  - err=1: fault_o pulses, pc = mtvec base.
  - err=0: pc = {rdata[31:1],1'b0}.
  - Then go to REDIRECT.
- REDIRECT:
  - redirect_valid_o=1 with pc stable until redirect_ready_i; valid&ready returns to IDLE.
  - Minimum latency from take to redirect_valid: non-shv 1 cycle; shv 3 cycles with zero-wait gnt/rvalid.
- Outside IDLE:
  - irq_ack_o and take_o stay 0; irq_valid_i/id changes are ignored.
  - mret_i is ignored (the pipeline is flushed and it cannot legally occur).
- Stray rvalid in IDLE or REDIRECT is ignored. Reset during FETCH_* drops req immediately; a later rvalid is ignored.
- Level registers saturate nowhere; width is PrioWidth. A level-0 request is never eligible.

Decomposition:
- zeroheti_pkg gets:
  - irq_taker_state_e (IDLE, FETCH_REQ, FETCH_RSP, REDIRECT)
  - VecEntryBytes=4
  - function mk_irq_cause(id) returning the 32-bit mcause
- One natural sub-module: zeroheti_vec_fetch. It is a single-outstanding OBI read engine (start/addr in; done/data/err out) driving obi_mgr.
- The eligibility compare and level registers stay in the top module.

Test Plan (num_irqs=64, num_prio=16):
- Non-shv take: mie=1, thresh=0, cur=0, valid id=5 level=3 shv=0, boundary=1, mtvec=0x100 -> same cycle ack=1, irq_id_o=5, cause=0x80000005; next cycle redirect_pc=0x100, cur_level=3, prev_level=0.
- shv fetch: id=10, mtvt=0x2000, rdata=0x0000_4001, zero-wait bus -> obi addr=0x2028; redirect_pc=0x4000 three cycles after take.
- Masking:
  - level=2 with thresh=2 -> no ack.
  - level=4, mie=0 -> no ack.
  - Same request with mie=1 but boundary=0 -> no ack until boundary=1.
- Nesting and mret: cur=3, request level 5 -> taken, prev=3, cur=5; after redirect, mret_i -> cur=3, prev=0. mret and an eligible request in the same cycle -> no take; take occurs the next cycle.
- Bus error: shv take, rvalid with err=1 -> fault_o pulse, redirect_pc=mtvec base; gnt held low 4 cycles -> req and addr stable throughout.
- Reset in FETCH_RSP: assert rst_i -> req=0, all outputs 0, levels 0; a subsequent rvalid causes no redirect.
